// File: rtl/vec_accel_pkg.sv
// Shared types and arithmetic helpers for the vector accelerator reduction stages.
package vec_accel_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} acc_state_t;

  localparam int DEFAULT_BITS     = 8;
  localparam int DEFAULT_ACC_BITS = 24;

  // Returns {sat_flag, clamped_sum}; overflow is detected when the extra sign bit disagrees.
  function automatic logic [DEFAULT_ACC_BITS:0] sat_add(
    input logic signed [DEFAULT_ACC_BITS-1:0] a,
    input logic signed [DEFAULT_ACC_BITS-1:0] b
  );
    logic signed [DEFAULT_ACC_BITS:0] sum;
    sum = {a[DEFAULT_ACC_BITS-1], a} + {b[DEFAULT_ACC_BITS-1], b};
    if (sum[DEFAULT_ACC_BITS] != sum[DEFAULT_ACC_BITS-1]) begin
      sat_add = {1'b1, sum[DEFAULT_ACC_BITS], {(DEFAULT_ACC_BITS-1){~sum[DEFAULT_ACC_BITS]}}};
    end else begin
      sat_add = {1'b0, sum[DEFAULT_ACC_BITS-1:0]};
    end
  endfunction

endpackage

// File: rtl/dot_accumulator_sat_adder.sv
// Combinational signed adder that clamps to the W-bit range and flags the clamp.
module sat_adder #(
  parameter int W = 24
) (
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  output logic signed [W-1:0] o_sum,
  output logic                o_sat
);

  logic signed [W:0] w_wide;

  assign w_wide = {i_a[W-1], i_a} + {i_b[W-1], i_b};
  assign o_sat  = w_wide[W] ^ w_wide[W-1];
  // The true sign (bit W) picks which rail to clamp to.
  assign o_sum  = o_sat ? {w_wide[W], {(W-1){~w_wide[W]}}} : w_wide[W-1:0];

endmodule

// File: rtl/dot_accumulator.sv
// Saturating reduction of a stream of signed products into one sum per vector,
// presented on a valid/ready result port.
module dot_accumulator
  import vec_accel_pkg::*;
#(
  parameter int BITS     = DEFAULT_BITS,
  parameter int ACC_BITS = DEFAULT_ACC_BITS,
  parameter int MAX_LEN  = 256,
  parameter int LEN_W    = $clog2(MAX_LEN + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [LEN_W-1:0]           len,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [BITS-1:0]     in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [ACC_BITS-1:0] out_data,
  output logic                       out_sat,
  output logic                       busy
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  acc_state_t                 r_state;
  acc_state_t                 w_state_next;
  logic signed [ACC_BITS-1:0] r_acc;
  logic [LEN_W-1:0]           r_count;
  logic [LEN_W-1:0]           r_len_q;
  logic                       r_sat;

  logic                       w_beat;
  logic                       w_last;
  logic [LEN_W-1:0]           w_count_inc;
  logic [LEN_W-1:0]           w_len_clamped;
  logic signed [ACC_BITS-1:0] w_in_ext;
  logic signed [ACC_BITS-1:0] w_sum;
  logic                       w_sum_sat;

  assign w_in_ext      = {{(ACC_BITS-BITS){in_data[BITS-1]}}, in_data};
  assign w_count_inc   = r_count + 1'b1;
  assign w_len_clamped = (len > MAX_LEN_L) ? MAX_LEN_L : len;
  assign w_beat        = in_valid && in_ready;
  assign w_last        = w_beat && (w_count_inc == r_len_q);

  sat_adder #(.W(ACC_BITS)) u_sat_adder (
    .i_a   (r_acc),
    .i_b   (w_in_ext),
    .o_sum (w_sum),
    .o_sat (w_sum_sat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath only moves on a new start (from IDLE) or an accepted beat; otherwise it holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_count <= '0;
      r_len_q <= '0;
      r_sat   <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_acc   <= '0;
      r_count <= '0;
      r_len_q <= w_len_clamped;
      r_sat   <= 1'b0;
    end else if (w_beat) begin
      r_acc   <= w_sum;
      r_count <= w_count_inc;
      if (w_sum_sat) begin
        r_sat <= 1'b1;
      end
    end
  end

  assign out_data = r_acc;
  assign out_sat  = r_sat;

endmodule

// File: doc/dot_accumulator.md
Name: dot_accumulator

Overview:
- Reduction stage directly downstream of the element-wise multiplier lanes.
- Consumes a stream of signed BITS-wide products and accumulates exactly len of them into one saturating ACC_BITS-wide sum.
- Presents the sum once per vector on a valid/ready output, to the HAL-visible result register.
- Turns element-wise multiply into a dot product.

Parameters:
- BITS, 8, width of each incoming product (matches multiplier P width)
- ACC_BITS, 24, accumulator/result width; must be greater than BITS
- MAX_LEN, 256, maximum vector length per operation
- LEN_W, $clog2(MAX_LEN+1), width of the len port (derived, not overridden)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle request to begin a new vector; honoured only in IDLE
- len  in  LEN_W  element count for this vector, sampled with start
- in_valid  in  1  product beat valid
- in_ready  out  1  accumulator accepts beat
- in_data  in  BITS  signed product from multiplier
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  ACC_BITS  signed accumulated sum
- out_sat  out  1  sticky: saturation occurred during this vector
- busy  out  1  high in ACCUM and DONE

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE; acc, count, len_q, out_sat all 0.
  - in_ready=0, out_valid=0, busy=0, out_data=0.
  - Reset mid-vector aborts with no output. Partial beats are discarded.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0.
  - On start=1:
    - Latch len_q=min(len, MAX_LEN); acc<=0; count<=0; out_sat<=0.
    - If len==0, go to DONE (out_data=0 on next cycle). Otherwise go to ACCUM.
- ACCUM:
  - in_ready=1 (combinational from state).
  - A beat transfers when in_valid&&in_ready.
  - On each beat: acc<=sat(acc+sext(in_data)); count<=count+1.
  - Beat taken with count==len_q-1 → DONE. in_ready drops the next cycle, so no extra beat is consumed.
  - No beat → hold all state.
- DONE:
  - out_valid=1; out_data=acc; out_sat as accumulated.
  - All held stable until out_ready=1, then IDLE on the next edge.
- Latency:
  - Last beat accepted at edge N → out_valid=1 from N, visible in cycle N+1.
  - Handshake completes at edge M → IDLE from M; the earliest next start is sampled at M+1.
- Arithmetic and saturation:
  - Sign-extend in_data to ACC_BITS+1 and add it to the sign-extended acc.
  - If the sum > 2^(ACC_BITS-1)-1, clamp to max; if < -2^(ACC_BITS-1), clamp to min. Either case sets out_sat sticky.
  - Accumulation continues from the clamped value (no wrap ever).
- start while busy: ignored (no effect on len_q or acc).
- start and out_ready together in DONE: start ignored; the result handshake completes.
- in_valid while not in ACCUM: ignored (in_ready=0).
- out_ready while out_valid=0: no effect.

Decomposition:
- Package vec_accel_pkg holds:
  - typedef enum logic [1:0] {IDLE, ACCUM, DONE} acc_state_t.
  - Shared BITS default constant.
  - Function sat_add(a, b) returning {sat_flag, clamped result}, reused by future reduction stages.
- One sub-module: sat_adder (parameter W). Combinational signed add with clamp and overflow flag. The FSM, counter and registers stay in dot_accumulator.

Test Plan:
- Basic dot product:
  - Stimulus: len=4, beats 3, -2, 10, 5 with in_valid held high.
  - Response: exactly 4 beats accepted; out_valid one cycle after the 4th; out_data=16; out_sat=0.
- Backpressure and gaps:
  - Stimulus: len=3, beats 7, 7, 7 with in_valid low for 2 cycles between beats; out_ready held low 5 cycles.
  - Response: out_data=21, stable with out_valid high all 5 cycles; IDLE after out_ready.
- Saturation (ACC_BITS=12):
  - Stimulus: len=20, all beats 127.
  - Response: out_data=2047, out_sat=1.
  - Next vector len=1, beat -128 → out_data=-128, out_sat=0 (sticky cleared on start).
- Boundaries:
  - len=0 → out_valid next cycle, out_data=0, no beats consumed.
  - len=MAX_LEN+10 → exactly MAX_LEN beats accepted.
- Ignored start and reset mid-operation:
  - Stimulus: start with len=2 pulsed during ACCUM of a len=5 vector.
  - Response: still 5 beats accepted.
  - Then assert rst_n=0 after 2 beats of a new vector → all outputs 0 next cycle, no out_valid, fresh start works normally.
